// File: rtl/multi_channel_debouncer.sv
// Multi-channel switch debouncer: two-flop sync, shared sample tick,
// per-channel stability filter, press/release/long-press strobes.
module multi_channel_debouncer #(
  parameter int WIDTH        = 4,
  parameter int TICK_DIV     = 500000,
  parameter int STABLE_TICKS = 3,
  parameter int LONG_TICKS   = 100
) (
  input  logic             FPGA_clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] debounced_out,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] long_pulse,
  output logic             any_change,
  output logic             tick
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (STABLE_TICKS > 0) ? $clog2(STABLE_TICKS + 1) : 1;
  localparam int HW = (LONG_TICKS > 0) ? $clog2(LONG_TICKS + 1) : 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_TICKS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_TICKS);

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [DW-1:0]    div_q, div_d;
  logic             tick_q, tick_d;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [WIDTH-1:0] press_q, press_d;
  logic [WIDTH-1:0] rel_q, rel_d;
  logic [WIDTH-1:0] long_q, long_d;
  logic             any_q, any_d;
  logic [SW-1:0]    stab_q [WIDTH];
  logic [SW-1:0]    stab_d [WIDTH];
  logic [HW-1:0]    hold_q [WIDTH];
  logic [HW-1:0]    hold_d [WIDTH];

  always_comb begin
    s1_d    = raw_in;
    s2_d    = s1_q;
    tick_d  = (div_q == DIV_LAST);
    div_d   = tick_d ? '0 : div_q + 1'b1;
    deb_d   = deb_q;
    press_d = '0;
    rel_d   = '0;
    long_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      stab_d[i] = stab_q[i];
      hold_d[i] = hold_q[i];
      if (tick_q) begin
        if (s2_q[i] == deb_q[i]) begin
          stab_d[i] = '0;
        end else if (stab_q[i] == STAB_LAST) begin
          deb_d[i]   = s2_q[i];
          stab_d[i]  = '0;
          press_d[i] = s2_q[i];
          rel_d[i]   = ~s2_q[i];
        end else begin
          stab_d[i] = stab_q[i] + 1'b1;
        end
      end
      // hold time restarts on every accepted press
      if (!deb_d[i] || press_d[i]) begin
        hold_d[i] = '0;
      end else if (tick_q && hold_q[i] != HOLD_MAX) begin
        hold_d[i] = hold_q[i] + 1'b1;
        long_d[i] = (hold_q[i] == HOLD_LAST);
      end
    end
    any_d = |(press_d | rel_d);
  end

  always_ff @(posedge FPGA_clock) begin
    if (reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      div_q   <= '0;
      tick_q  <= 1'b0;
      deb_q   <= '0;
      press_q <= '0;
      rel_q   <= '0;
      long_q  <= '0;
      any_q   <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        stab_q[i] <= '0;
        hold_q[i] <= '0;
      end
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      deb_q   <= deb_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      any_q   <= any_d;
      for (int i = 0; i < WIDTH; i++) begin
        stab_q[i] <= stab_d[i];
        hold_q[i] <= hold_d[i];
      end
    end
  end

  assign debounced_out = deb_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign long_pulse    = long_q;
  assign any_change    = any_q;
  assign tick          = tick_q;

endmodule

// File: tb/tb_multi_channel_debouncer.sv
// Bench for multi_channel_debouncer: behavioural model plus
// directed and random scenarios, and a degenerate-parameter instance.
module tb_multi_channel_debouncer;

  localparam int TD = 4;
  localparam int ST = 3;
  localparam int LT = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] raw_in;
  logic [3:0] raw2;
  logic [3:0] deb, press, rel, lng;
  logic       any, tick;
  logic [3:0] deb2, press2, rel2, lng2;
  logic       any2, tick2;

  multi_channel_debouncer #(
    .WIDTH(4), .TICK_DIV(TD), .STABLE_TICKS(ST), .LONG_TICKS(LT)
  ) dut (
    .FPGA_clock(clk), .reset(reset), .raw_in(raw_in),
    .debounced_out(deb), .press_pulse(press), .release_pulse(rel),
    .long_pulse(lng), .any_change(any), .tick(tick)
  );

  multi_channel_debouncer #(
    .WIDTH(4), .TICK_DIV(1), .STABLE_TICKS(1), .LONG_TICKS(LT)
  ) dut2 (
    .FPGA_clock(clk), .reset(reset), .raw_in(raw2),
    .debounced_out(deb2), .press_pulse(press2), .release_pulse(rel2),
    .long_pulse(lng2), .any_change(any2), .tick(tick2)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad = 0;
  int    mm = 0;
  string mm_msg = "";

  // behavioural model state
  int         m_cyc;
  logic       m_tick;
  logic [3:0] m_s1, m_s2, m_deb, m_press, m_rel, m_long;
  logic       m_any;
  int         m_run [4];
  int         m_held [4];

  task automatic model_update(input logic [3:0] r, input logic rst);
    logic [3:0] s2_now;
    logic       tk;
    if (rst) begin
      m_cyc = 0; m_tick = 1'b0;
      m_s1 = '0; m_s2 = '0; m_deb = '0;
      m_press = '0; m_rel = '0; m_long = '0; m_any = 1'b0;
      for (int i = 0; i < 4; i++) begin
        m_run[i] = 0; m_held[i] = 0;
      end
    end else begin
      s2_now = m_s2;
      tk = m_tick;
      m_s2 = m_s1;
      m_s1 = r;
      m_cyc++;
      m_tick = (m_cyc % TD == 0);
      m_press = '0; m_rel = '0; m_long = '0;
      for (int i = 0; i < 4; i++) begin
        if (tk) begin
          if (s2_now[i] == m_deb[i]) m_run[i] = 0;
          else begin
            m_run[i]++;
            if (m_run[i] == ST) begin
              m_deb[i] = s2_now[i];
              m_run[i] = 0;
              if (s2_now[i]) m_press[i] = 1'b1;
              else m_rel[i] = 1'b1;
            end
          end
        end
        if (!m_deb[i] || m_press[i]) m_held[i] = 0;
        else if (tk && m_held[i] < LT) begin
          m_held[i]++;
          if (m_held[i] == LT) m_long[i] = 1'b1;
        end
      end
      m_any = |(m_press | m_rel);
    end
  endtask

  // one clock: drive at negedge, model on posedge, observe at next negedge
  task automatic step(input logic [3:0] r, input logic rst);
    raw_in = r;
    reset = rst;
    @(posedge clk);
    model_update(r, rst);
    @(negedge clk);
    if ({deb, press, rel, lng, any, tick} !==
        {m_deb, m_press, m_rel, m_long, m_any, m_tick}) begin
      mm++;
      if (mm == 1)
        mm_msg = $sformatf("t=%0t got d%h p%h r%h l%h a%b t%b need d%h p%h r%h l%h a%b t%b",
          $time, deb, press, rel, lng, any, tick,
          m_deb, m_press, m_rel, m_long, m_any, m_tick);
    end
  endtask

  task automatic test_reset();
    int first_tick, press_at, npress;
    mm = 0;
    for (int k = 0; k < 3; k++) begin
      step(4'hF, 1'b1);
      total++;
      if ({deb, press, rel, lng, any, tick} !== 18'd0) begin
        bad++;
        $display("FAIL reset_hold: outputs=%h required=0",
          {deb, press, rel, lng, any, tick});
      end
    end
    first_tick = -1; press_at = -1; npress = 0;
    for (int k = 1; k <= 20; k++) begin
      step(4'hF, 1'b0);
      if (tick && first_tick < 0) first_tick = k;
      if (press == 4'hF && press_at < 0) press_at = k;
      if (press != 0) npress++;
    end
    total++;
    if (first_tick !== 4) begin
      bad++; $display("FAIL first_tick: cycle=%0d required=4", first_tick);
    end
    total++;
    if (press_at !== 13) begin
      bad++; $display("FAIL reset_press: cycle=%0d required=13", press_at);
    end
    total++;
    if (npress !== 1) begin
      bad++; $display("FAIL reset_press_width: cycles=%0d required=1", npress);
    end
    total++;
    if (deb !== 4'hF) begin
      bad++; $display("FAIL reset_deb: deb=%h required=f", deb);
    end
    total++;
    if (mm !== 0) begin
      bad++; $display("FAIL model_reset: mismatches=%0d required=0 %s", mm, mm_msg);
    end
  endtask

  task automatic test_bounce();
    int np, n0, nother;
    mm = 0;
    for (int k = 0; k < 3; k++) step(4'h0, 1'b1);
    for (int k = 0; k < 20; k++) step(4'h0, 1'b0);
    np = 0;
    for (int c = 0; c < 60; c++) begin
      step({3'b000, ((c / 5) % 2 == 0)}, 1'b0);
      if (press != 0) np++;
    end
    total++;
    if (np !== 0) begin
      bad++; $display("FAIL bounce_press: count=%0d required=0", np);
    end
    n0 = 0; nother = 0;
    for (int c = 0; c < 40; c++) begin
      step(4'b0001, 1'b0);
      if (press[0]) n0++;
      if (press[3:1] != 0) nother++;
    end
    total++;
    if (n0 !== 1) begin
      bad++; $display("FAIL bounce_settle: count=%0d required=1", n0);
    end
    total++;
    if (nother !== 0 || deb !== 4'b0001) begin
      bad++; $display("FAIL bounce_other: others=%0d deb=%h required=0 1", nother, deb);
    end
    total++;
    if (mm !== 0) begin
      bad++; $display("FAIL model_bounce: mismatches=%0d required=0 %s", mm, mm_msg);
    end
  endtask

  task automatic test_long_press();
    int seen, ticks, got, extra, again;
    mm = 0;
    seen = 0;
    for (int k = 0; k < 40 && seen == 0; k++) begin
      step(4'b0011, 1'b0);
      if (press[1]) seen = 1;
    end
    ticks = 0; got = -1;
    for (int k = 0; k < 40 && got < 0; k++) begin
      step(4'b0011, 1'b0);
      if (lng[1]) got = ticks;
      else if (tick) ticks++;
    end
    total++;
    if (seen !== 1 || got !== LT) begin
      bad++; $display("FAIL long_delay: press=%0d ticks=%0d required=1 %0d", seen, got, LT);
    end
    extra = 0;
    for (int k = 0; k < 20 * TD; k++) begin
      step(4'b0011, 1'b0);
      if (lng[1]) extra++;
    end
    total++;
    if (extra !== 0) begin
      bad++; $display("FAIL long_repeat: count=%0d required=0", extra);
    end
    for (int k = 0; k < 30; k++) step(4'b0001, 1'b0);
    again = 0;
    for (int k = 0; k < 60; k++) begin
      step(4'b0011, 1'b0);
      if (lng[1]) again++;
    end
    total++;
    if (again !== 1) begin
      bad++; $display("FAIL long_repress: count=%0d required=1", again);
    end
    total++;
    if (mm !== 0) begin
      bad++; $display("FAIL model_long: mismatches=%0d required=0 %s", mm, mm_msg);
    end
  endtask

  task automatic test_release();
    int nrel, nany;
    mm = 0;
    for (int k = 0; k < 30; k++) step(4'b0111, 1'b0);
    nrel = 0; nany = 0;
    for (int k = 0; k < 30; k++) begin
      step(4'b0011, 1'b0);
      if (rel[2]) nrel++;
      if (any) nany++;
    end
    total++;
    if (nrel !== 1 || nany !== 1) begin
      bad++; $display("FAIL release_count: rel=%0d any=%0d required=1 1", nrel, nany);
    end
    total++;
    if (deb !== 4'b0011) begin
      bad++; $display("FAIL release_deb: deb=%h required=3", deb);
    end
    total++;
    if (mm !== 0) begin
      bad++; $display("FAIL model_release: mismatches=%0d required=0 %s", mm, mm_msg);
    end
  endtask

  task automatic test_simul_and_reset();
    int p0, p3, ticks, k, np, pat;
    mm = 0;
    for (int j = 0; j < 3; j++) step(4'h0, 1'b1);
    for (int j = 0; j < 10; j++) step(4'h0, 1'b0);
    p0 = -1; p3 = -1;
    for (int j = 1; j <= 30; j++) begin
      step(4'b1001, 1'b0);
      if (press[0] && p0 < 0) p0 = j;
      if (press[3] && p3 < 0) p3 = j;
    end
    total++;
    if (p0 < 0 || p0 !== p3) begin
      bad++; $display("FAIL simul_press: ch0=%0d ch3=%0d required equal", p0, p3);
    end
    for (int j = 0; j < 3; j++) step(4'h0, 1'b1);
    for (int j = 0; j < 12; j++) step(4'h0, 1'b0);
    ticks = 0; k = 0; np = 0;
    while (ticks < 2 && k < 40) begin
      step(4'b0100, 1'b0);
      k++;
      if (k >= 2 && tick) ticks++;
      if (press != 0) np++;
    end
    step(4'b0100, 1'b0);
    if (press != 0) np++;
    step(4'b0100, 1'b1);
    total++;
    if (np !== 0 || ticks !== 2 || deb !== 4'h0) begin
      bad++; $display("FAIL midreset_pending: press=%0d ticks=%0d deb=%h required=0 2 0", np, ticks, deb);
    end
    pat = -1;
    for (int j = 1; j <= 40 && pat < 0; j++) begin
      step(4'b0100, 1'b0);
      if (press[2]) pat = j;
    end
    total++;
    if (pat !== 13) begin
      bad++; $display("FAIL midreset_latency: cycle=%0d required=13", pat);
    end
    total++;
    if (mm !== 0) begin
      bad++; $display("FAIL model_simul: mismatches=%0d required=0 %s", mm, mm_msg);
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    int np;
    mm = 0;
    for (int j = 0; j < 3; j++) step(4'h0, 1'b1);
    r = 4'($urandom);
    np = 0;
    for (int j = 0; j < 1500; j++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(11) == 0) r[i] = ~r[i];
      step(r, 1'b0);
      if (press != 0) np++;
    end
    total++;
    if (np == 0) begin
      bad++; $display("FAIL random_activity: presses=%0d required>0", np);
    end
    total++;
    if (mm !== 0) begin
      bad++; $display("FAIL model_random: mismatches=%0d required=0 %s", mm, mm_msg);
    end
  endtask

  task automatic test_degenerate();
    logic [3:0] hist [64];
    logic [3:0] prev;
    int e_deb, e_tick, e_edge;
    raw2 = 4'h0;
    for (int j = 0; j < 2; j++) step(4'h0, 1'b1);
    e_deb = 0; e_tick = 0; e_edge = 0;
    prev = deb2;
    for (int n = 1; n < 64; n++) begin
      raw2 = 4'($urandom);
      hist[n] = raw2;
      step(4'h0, 1'b0);
      if (tick2 !== 1'b1) e_tick++;
      if (n >= 3) begin
        if (deb2 !== hist[n-2]) e_deb++;
        if (press2 !== (deb2 & ~prev) || rel2 !== (~deb2 & prev) ||
            any2 !== |(deb2 ^ prev)) e_edge++;
      end
      prev = deb2;
    end
    total++;
    if (e_tick !== 0) begin
      bad++; $display("FAIL degen_tick: lowcycles=%0d required=0", e_tick);
    end
    total++;
    if (e_deb !== 0) begin
      bad++; $display("FAIL degen_delay: errors=%0d required=0", e_deb);
    end
    total++;
    if (e_edge !== 0) begin
      bad++; $display("FAIL degen_strobes: errors=%0d required=0", e_edge);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time=%0t required=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    raw_in = 4'h0;
    raw2 = 4'h0;
    @(negedge clk);
    test_reset();
    test_bounce();
    test_long_press();
    test_release();
    test_simul_and_reset();
    test_random();
    test_degenerate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_channel_debouncer.md
# multi_channel_debouncer

Parametrised multi-channel switch/button debouncer for the messenger front panel. It synchronises WIDTH raw inputs into FPGA_clock and filters each one with its own stability counter, sampled on a shared tick. It produces debounced levels plus one-cycle press, release and long-press strobes, so the message and emoji logic never sees contact bounce. All logic runs on FPGA_clock using a clock-enable tick; there are no derived clocks.

## Interface
- WIDTH, 4: number of independent input channels.
- TICK_DIV, 500000: FPGA_clock cycles per sample tick (≥1).
- STABLE_TICKS, 3: consecutive differing samples required to accept a new level (≥1).
- LONG_TICKS, 100: ticks a channel must stay pressed before long_pulse fires (≥1).
- FPGA_clock  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- raw_in  in  WIDTH  asynchronous raw switch/button levels, 1 = pressed.
- debounced_out  out  WIDTH  filtered levels.
- press_pulse  out  WIDTH  one-cycle strobe on each accepted 0→1 transition.
- release_pulse  out  WIDTH  one-cycle strobe on each accepted 1→0 transition.
- long_pulse  out  WIDTH  one-cycle strobe when a channel has been held LONG_TICKS ticks.
- any_change  out  1  OR of press_pulse and release_pulse.
- tick  out  1  sample-tick strobe, for debug and for use by downstream logic.

## Operation
- Synchroniser: two flops per channel, raw_in → s1 → s2. Only s2 is used downstream.
- Tick generator: div_cnt is $clog2(TICK_DIV) bits wide (minimum 1) and counts 0..TICK_DIV-1.
  - tick = 1 for exactly one cycle when div_cnt == TICK_DIV-1; div_cnt then wraps to 0.
  - With TICK_DIV=1, tick is high every cycle.
- Per-channel filter: stab_cnt is $clog2(STABLE_TICKS+1) bits wide. On a cycle with tick = 1:
  - If s2[i] == debounced_out[i]: stab_cnt ← 0.
  - Else if stab_cnt + 1 == STABLE_TICKS: debounced_out[i] ← s2[i], stab_cnt ← 0, and the matching press_pulse or release_pulse bit ← 1.
  - Else: stab_cnt ← stab_cnt + 1.
  - On non-tick cycles stab_cnt and debounced_out hold. Glitches between ticks are invisible.
  - With STABLE_TICKS=1, the output follows s2 at every tick.
- Long press: hold_cnt is $clog2(LONG_TICKS+1) bits wide and saturating.
  - Cleared whenever debounced_out[i] = 0, and on the same edge as press_pulse[i].
  - While debounced_out[i] = 1, it increments on each tick.
  - When it increments to exactly LONG_TICKS, long_pulse[i] = 1 for one cycle. After that it saturates, so there is no repeat until the channel is released and pressed again.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous strobes.
- Reset: s1, s2, div_cnt, all stab_cnt, all hold_cnt, debounced_out, press_pulse, release_pulse, long_pulse, any_change and tick are all 0.
  - Reset applied mid-filter discards any partial count.
  - After reset deassertion, a raw_in held at 1 is reported as a fresh press once STABLE_TICKS ticks have elapsed.

## Timing
- All outputs are registered. Strobes are high for exactly one FPGA_clock cycle.
- press_pulse and release_pulse assert on the same edge that debounced_out changes. any_change asserts on that edge as well.
- long_pulse asserts on the tick edge where hold_cnt reaches LONG_TICKS.
- Acceptance latency, raw edge to debounced_out change:
  - 2 cycles of synchronisation, then the STABLE_TICKS-th tick whose sample shows the new level.
  - Maximum is 2 + STABLE_TICKS × TICK_DIV cycles.
- A return to the old level on any tick before acceptance restarts the count. The rule is strictly consecutive samples.
- tick is the registered compare of div_cnt: first tick TICK_DIV cycles after reset release, then periodic with period TICK_DIV.

## Test plan
All scenarios use WIDTH=4, TICK_DIV=4, STABLE_TICKS=3, LONG_TICKS=5 unless stated.
- Reset check: hold reset 3 cycles with raw_in=4'hF → all outputs 0 during reset. First tick 4 cycles after release. debounced_out=4'hF and press_pulse=4'hF (one cycle) on the 3rd tick.
- Bounce rejection: raw_in[0] toggles 1/0 every 5 cycles for 60 cycles, then settles at 1 → no press_pulse during bouncing. Exactly one press_pulse[0] after 3 consecutive high ticks. Other channels stay 0.
- Release plus any_change: after a settled press on ch2, drive raw_in[2]=0 → one release_pulse[2] and one any_change pulse on the 3rd low tick. debounced_out[2]=0 from that edge.
- Long press: hold ch1 pressed → long_pulse[1] exactly once, 5 ticks after press_pulse[1]. No further long_pulse while held for 20 more ticks. Release then re-press → long_pulse fires again.
- Simultaneous channels plus reset mid-count: raise ch0 and ch3 on the same cycle → both press strobes fire on the same edge. Separately, assert reset after 2 ticks of a pending change → no strobe, counts cleared, and the full 3 ticks are required after release.
- Degenerate parameters: TICK_DIV=1, STABLE_TICKS=1 → tick constant 1, and debounced_out equals raw_in delayed by 3 cycles.
